// File: rtl/enemy_ai_if.sv
// Command/observation bundle between the game world and the enemy AI block.
interface enemy_ai_if;
  logic               tick;
  logic               enable;
  logic signed [10:0] player_x;
  logic signed [10:0] enemy_x;
  logic               player_atk;
  logic               enemy_isJ;
  logic               right;
  logic               left;
  logic               jump;
  logic               squat;
  logic               defend;
  logic [2:0]         state;

  modport master (
    output tick, enable, player_x, enemy_x, player_atk, enemy_isJ,
    input  right, left, jump, squat, defend, state
  );

  modport slave (
    input  tick, enable, player_x, enemy_x, player_atk, enemy_isJ,
    output right, left, jump, squat, defend, state
  );
endinterface

// File: rtl/enemy_ai.sv
// Enemy AI: periodic and attack-triggered decisions turned into registered movement commands.
// Optional feature: define ENEMY_AI_SQUAT_EN to let GUARD pick squat instead of defend.
module enemy_ai #(
  parameter int DECIDE_PERIOD = 8,
  parameter int CHASE_RANGE   = 200,
  parameter int MIN_RANGE     = 64,
  parameter int ATK_RANGE     = 96,
  parameter int JUMP_CD       = 30
) (
  input logic       clk,
  input logic       rst,
  enemy_ai_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CHASE = 3'd1, RETREAT = 3'd2, GUARD = 3'd3, EVADE = 3'd4
  } state_t;

  localparam logic [7:0]  LAST_CNT  = 8'(DECIDE_PERIOD - 1);
  localparam logic [7:0]  CD_LOAD   = 8'(JUMP_CD);
  localparam logic [11:0] CHASE_R   = 12'(CHASE_RANGE);
  localparam logic [11:0] MIN_R     = 12'(MIN_RANGE);
  localparam logic [11:0] ATK_R     = 12'(ATK_RANGE);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  state_t             st, dec_st;
  logic [7:0]         cnt, cd;
  logic [15:0]        lfsr;
  logic               atk_q, atk_pend;
  logic               right_q, left_q, jump_q, defend_q;
  logic signed [11:0] dx;
  logic [11:0]        adx;
  logic               atk_rise, decide;
  logic               nxt_right, nxt_left, nxt_jump, nxt_defend;

  // One extra sign bit makes the difference of any two 11-bit positions exact.
  assign dx  = {bus.player_x[10], bus.player_x} - {bus.enemy_x[10], bus.enemy_x};
  assign adx = dx[11] ? 12'(-dx) : 12'(dx);

  assign atk_rise = bus.player_atk & ~atk_q;
  assign decide   = atk_pend | atk_rise | (cnt == LAST_CNT);

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    dec_st = IDLE;
    if (bus.player_atk && adx <= ATK_R)
      dec_st = (lfsr[0] && cd == 8'd0 && !bus.enemy_isJ) ? EVADE : GUARD;
    else if (adx > CHASE_R)
      dec_st = CHASE;
    else if (adx < MIN_R)
      dec_st = RETREAT;
  end

`ifdef ENEMY_AI_SQUAT_EN
  logic squat_q, nxt_squat;
`endif

  always_comb begin
    nxt_right  = 1'b0;
    nxt_left   = 1'b0;
    nxt_jump   = 1'b0;
    nxt_defend = 1'b0;
`ifdef ENEMY_AI_SQUAT_EN
    nxt_squat  = 1'b0;
`endif
    case (dec_st)
      CHASE:   begin nxt_left = dx[11];  nxt_right = ~dx[11]; end
      RETREAT: begin nxt_left = ~dx[11]; nxt_right = dx[11];  end
`ifdef ENEMY_AI_SQUAT_EN
      GUARD:   begin nxt_squat = lfsr[2]; nxt_defend = ~lfsr[2]; end
`else
      GUARD:   nxt_defend = 1'b1;
`endif
      EVADE:   nxt_jump = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= 8'd0;
      cd       <= 8'd0;
      lfsr     <= LFSR_SEED;
      atk_q    <= 1'b0;
      atk_pend <= 1'b0;
      right_q  <= 1'b0;
      left_q   <= 1'b0;
      jump_q   <= 1'b0;
      defend_q <= 1'b0;
`ifdef ENEMY_AI_SQUAT_EN
      squat_q  <= 1'b0;
`endif
    end else begin
      atk_q <= bus.player_atk;
      // LFSR and cooldown keep running even while the AI is disabled.
      if (bus.tick) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (st == EVADE)     cd <= CD_LOAD;
        else if (cd != 8'd0) cd <= cd - 8'd1;
      end
      if (!bus.enable) begin
        st       <= IDLE;
        cnt      <= 8'd0;
        atk_pend <= 1'b0;
        right_q  <= 1'b0;
        left_q   <= 1'b0;
        jump_q   <= 1'b0;
        defend_q <= 1'b0;
`ifdef ENEMY_AI_SQUAT_EN
        squat_q  <= 1'b0;
`endif
      end else if (bus.tick) begin
        cnt      <= decide ? 8'd0 : cnt + 8'd1;
        atk_pend <= 1'b0;
        case (st)
          // EVADE lasts exactly one tick; any decision on that tick is consumed but ignored.
          IDLE, CHASE, RETREAT, GUARD: begin
            if (decide) begin
              st       <= dec_st;
              right_q  <= nxt_right;
              left_q   <= nxt_left;
              jump_q   <= nxt_jump;
              defend_q <= nxt_defend;
`ifdef ENEMY_AI_SQUAT_EN
              squat_q  <= nxt_squat;
`endif
            end
          end
          default: begin
            st       <= IDLE;
            right_q  <= 1'b0;
            left_q   <= 1'b0;
            jump_q   <= 1'b0;
            defend_q <= 1'b0;
`ifdef ENEMY_AI_SQUAT_EN
            squat_q  <= 1'b0;
`endif
          end
        endcase
      end else if (atk_rise) begin
        atk_pend <= 1'b1;
      end
    end
  end

  assign bus.right  = right_q;
  assign bus.left   = left_q;
  assign bus.jump   = jump_q;
  assign bus.defend = defend_q;
  assign bus.state  = st;
`ifdef ENEMY_AI_SQUAT_EN
  assign bus.squat  = squat_q & ~bus.enemy_isJ;
`else
  assign bus.squat  = 1'b0;
`endif
endmodule

// File: tb/tb_enemy_ai.sv
// Self-checking bench for enemy_ai: directed scenarios plus a randomized run against a behavioural model.
module tb_enemy_ai;
  localparam int PERIOD = 8;
  localparam int CHASE_RANGE = 200;
  localparam int MIN_RANGE = 64;
  localparam int ATK_RANGE = 96;
  localparam int JUMP_CD = 30;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  enemy_ai_if bus ();

  enemy_ai #(
    .DECIDE_PERIOD(PERIOD), .CHASE_RANGE(CHASE_RANGE), .MIN_RANGE(MIN_RANGE),
    .ATK_RANGE(ATK_RANGE), .JUMP_CD(JUMP_CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference model, evaluated from the rules at each rising edge.
  int          m_state, m_cnt, m_cd;
  bit          m_pend, m_atkq;
  bit          m_r, m_l, m_j, m_d, m_s;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    int dx, adx, nxt, cd0;
    bit rise, dec;
    logic [15:0] l0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_cd = 0; m_pend = 0; m_atkq = 0;
      m_r = 0; m_l = 0; m_j = 0; m_d = 0; m_s = 0;
      m_lfsr = 16'hACE1;
    end else begin
      dx   = int'(bus.player_x) - int'(bus.enemy_x);
      adx  = (dx < 0) ? -dx : dx;
      rise = bus.player_atk && !m_atkq;
      l0   = m_lfsr;
      cd0  = m_cd;
      if (bus.tick) begin
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        if (m_state == 4) m_cd = JUMP_CD;
        else if (m_cd > 0) m_cd = m_cd - 1;
      end
      if (!bus.enable) begin
        m_state = 0; m_cnt = 0; m_pend = 0;
        m_r = 0; m_l = 0; m_j = 0; m_d = 0; m_s = 0;
      end else if (bus.tick) begin
        dec    = m_pend || rise || (m_cnt == PERIOD - 1);
        m_cnt  = dec ? 0 : m_cnt + 1;
        m_pend = 0;
        if (m_state == 4) begin
          m_state = 0;
          m_r = 0; m_l = 0; m_j = 0; m_d = 0; m_s = 0;
        end else if (dec) begin
          if (bus.player_atk && adx <= ATK_RANGE)
            nxt = (l0[0] && cd0 == 0 && !bus.enemy_isJ) ? 4 : 3;
          else if (adx > CHASE_RANGE) nxt = 1;
          else if (adx < MIN_RANGE)   nxt = 2;
          else                        nxt = 0;
          m_state = nxt;
          m_r = (nxt == 1 && dx >= 0) || (nxt == 2 && dx < 0);
          m_l = (nxt == 1 && dx < 0)  || (nxt == 2 && dx >= 0);
          m_j = (nxt == 4);
`ifdef ENEMY_AI_SQUAT_EN
          m_s = (nxt == 3) && l0[2];
          m_d = (nxt == 3) && !l0[2];
`else
          m_s = 0;
          m_d = (nxt == 3);
`endif
        end
      end else if (rise) begin
        m_pend = 1;
      end
      m_atkq = bus.player_atk;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"},  16'(bus.state),  16'(m_state));
    check({tag, ".right"},  16'(bus.right),  16'(m_r));
    check({tag, ".left"},   16'(bus.left),   16'(m_l));
    check({tag, ".jump"},   16'(bus.jump),   16'(m_j));
    check({tag, ".defend"}, 16'(bus.defend), 16'(m_d));
    check({tag, ".squat"},  16'(bus.squat),  16'(m_s && !bus.enemy_isJ));
    check({tag, ".onehot"}, 16'($countones({bus.right, bus.left, bus.jump, bus.squat, bus.defend}) <= 1), 16'd1);
    check({tag, ".lfsr"},   dut.lfsr,        m_lfsr);
  endtask

  task automatic cyc(input logic t, input string tag);
    bus.tick = t;
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, tag);
      cyc(1'b0, tag);
    end
  endtask

  task automatic attack(input string tag);
    bus.player_atk = 1'b0;
    cyc(1'b0, tag);
    bus.player_atk = 1'b1;
    cyc(1'b0, tag);
    cyc(1'b1, tag);
  endtask

  initial begin
    int tries;
    int adx_tab[4] = '{63, 64, 200, 201};
    int exp_tab[4] = '{2, 0, 0, 1};

    rst = 1'b1;
    bus.tick = 1'b0; bus.enable = 1'b1; bus.player_atk = 1'b0; bus.enemy_isJ = 1'b0;
    bus.player_x = 11'sd0; bus.enemy_x = 11'sd0;
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    check("reset_lfsr", dut.lfsr, 16'hACE1);
    check("reset_state", 16'(bus.state), 16'd0);
    rst = 1'b0;

    // Far player to the left: CHASE with left after the 8th tick.
    bus.player_x = -11'sd300; bus.enemy_x = 11'sd100;
    ticks(7, "chase_wait");
    check("chase_pre_state", 16'(bus.state), 16'd0);
    ticks(1, "chase");
    check("chase_state", 16'(bus.state), 16'd1);
    check("chase_left", 16'(bus.left), 16'd1);

    // Close player to the left: RETREAT moves right.
    bus.player_x = 11'sd50; bus.enemy_x = 11'sd80;
    ticks(PERIOD, "retreat");
    check("retreat_state", 16'(bus.state), 16'd2);
    check("retreat_right", 16'(bus.right), 16'd1);

    // Attack mid-period forces a decision on the next tick.
    bus.player_x = 11'sd0; bus.enemy_x = 11'sd60;
    ticks(3, "atk_mid");
    bus.player_atk = 1'b1;
    cyc(1'b0, "atk_pend");
    check("atk_pend_hold", 16'(bus.state), 16'd2);
    cyc(1'b1, "atk_decide");
    check("atk_guard_or_evade", 16'((bus.state == 3'd3) || (bus.state == 3'd4)), 16'd1);
    tries = 0;
    while (bus.state != 3'd4 && tries < 40) begin
      attack("atk_retry");
      tries++;
    end
    check("evade_reached", 16'(bus.state), 16'd4);
    check("evade_jump", 16'(bus.jump), 16'd1);
    cyc(1'b0, "evade_hold");
    check("evade_hold_jump", 16'(bus.jump), 16'd1);
    cyc(1'b1, "evade_exit");
    check("evade_exit_state", 16'(bus.state), 16'd0);
    check("evade_exit_jump", 16'(bus.jump), 16'd0);
    for (int k = 0; k < 3; k++) begin
      attack("cooldown_atk");
      check("cooldown_guard", 16'(bus.state), 16'd3);
      check("cooldown_defend", 16'(bus.defend), 16'd1);
    end
    bus.player_atk = 1'b0;

    // Enable drop in CHASE, then a full period after re-enable.
    bus.player_x = -11'sd300; bus.enemy_x = 11'sd100;
    for (int k = 0; k < 20 && bus.state != 3'd1; k++) ticks(1, "chase_again");
    check("chase_again_state", 16'(bus.state), 16'd1);
    bus.enable = 1'b0;
    cyc(1'b0, "disable");
    check("disable_state", 16'(bus.state), 16'd0);
    check("disable_left", 16'(bus.left), 16'd0);
    ticks(3, "disabled");
    bus.enable = 1'b1;
    ticks(PERIOD - 1, "reenable_wait");
    check("reenable_pre_state", 16'(bus.state), 16'd0);
    ticks(1, "reenable");
    check("reenable_state", 16'(bus.state), 16'd1);

    // dx = 0 retreats to the left.
    bus.player_x = 11'sd100; bus.enemy_x = 11'sd100;
    ticks(PERIOD, "dx_zero");
    check("dx_zero_state", 16'(bus.state), 16'd2);
    check("dx_zero_left", 16'(bus.left), 16'd1);

    // Range thresholds.
    for (int k = 0; k < 4; k++) begin
      bus.player_x = 11'(100 + adx_tab[k]);
      ticks(PERIOD, "range");
      check($sformatf("range_%0d", adx_tab[k]), 16'(bus.state), 16'(exp_tab[k]));
    end

    // Attack range boundary.
    bus.player_x = 11'sd197;
    attack("atk_97");
    check("atk_97_state", 16'(bus.state), 16'd0);
    bus.player_x = 11'sd196;
    attack("atk_96");
    check("atk_96_threat", 16'((bus.state == 3'd3) || (bus.state == 3'd4)), 16'd1);
    bus.player_atk = 1'b0;
    ticks(2, "atk_96_after");

    // Reset together with tick and an attack edge.
    rst = 1'b1; bus.tick = 1'b1; bus.player_atk = 1'b1;
    @(negedge clk);
    compare_all("rst_tick");
    check("rst_tick_lfsr", dut.lfsr, 16'hACE1);
    check("rst_tick_cmds", 16'({bus.right, bus.left, bus.jump, bus.squat, bus.defend}), 16'd0);
    rst = 1'b0; bus.tick = 1'b0; bus.player_atk = 1'b0;
    cyc(1'b0, "rst_release");

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.enable = ($urandom_range(0, 59) != 0);
      bus.enemy_isJ = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) bus.player_atk = ~bus.player_atk;
      if ($urandom_range(0, 7) == 0) begin
        bus.enemy_x = 11'($urandom_range(0, 2047));
        if ($urandom_range(0, 1) == 0)
          bus.player_x = bus.enemy_x + 11'($urandom_range(0, 500)) - 11'd250;
        else
          bus.player_x = 11'($urandom_range(0, 2047));
      end
      cyc(($urandom_range(0, 2) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
